// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - SoC-side receive FIFO access bus for uart_rx_ctrl
interface uart_rx_ctrl_if #(
  parameter int DATA       = 8,
  parameter int DEPTH_LOG2 = 2
);
  logic [DATA-1:0]     o_data;
  logic                o_valid;
  logic                i_rd;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_overrun;
  logic                i_clr_overrun;
  logic                i_flush;

  // slave: the controller that owns the FIFO
  modport slave (
    output o_data, o_valid, o_count, o_overrun,
    input  i_rd, i_clr_overrun, i_flush
  );

  // master: the SoC-side reader
  modport master (
    input  o_data, o_valid, o_count, o_overrun,
    output i_rd, i_clr_overrun, i_flush
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: tick gen, pin sync, idle gating, byte FIFO (optional UART_RX_CTRL_STATS_EN)
module uart_rx_ctrl #(
  parameter int DATA       = 8,
  parameter int DIV_W      = 16,
  parameter int OSR        = 16,
  parameter int IDLE_BITS  = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic             i_rx_pin,
  output logic             o_rx_sync,
  output logic             o_os_tick,
  output logic             o_core_rst,
  input  logic [DATA-1:0]  i_core_data,
  input  logic             i_core_ready,
  output logic [1:0]       o_state,
`ifdef UART_RX_CTRL_STATS_EN
  output logic [15:0]      o_byte_count,
  output logic [7:0]       o_drop_count,
`endif
  uart_rx_ctrl_if.slave    bus
);

  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int IDLE_TARGET = IDLE_BITS * OSR;
  localparam int IDLE_W      = $clog2(IDLE_TARGET + 1);
  localparam int PTR_W       = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic              rx_meta;
  logic [DIV_W-1:0]  div_cnt;
  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              ready_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, count;
  logic [DATA-1:0]   mem [DEPTH];
  logic              full, empty, new_byte, do_push, do_pop, drop;
  logic              overrun;

  // Two-flop synchroniser, preset high so the line looks idle out of reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta   <= 1'b1;
      o_rx_sync <= 1'b1;
    end else begin
      rx_meta   <= i_rx_pin;
      o_rx_sync <= rx_meta;
    end
  end

  // Oversample tick; >= compare lets a shrunken divisor fire at once instead of wrapping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt   <= '0;
      o_os_tick <= 1'b0;
    end else if (!i_en) begin
      div_cnt   <= '0;
      o_os_tick <= 1'b0;
    end else if (div_cnt >= i_divisor) begin
      div_cnt   <= '0;
      o_os_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
      o_os_tick <= 1'b0;
    end
  end

  // FSM state and idle-time counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_OFF;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Next state: core is released only after IDLE_BITS bit times of unbroken high line
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    if (!i_en) begin
      state_nxt = ST_OFF;
      idle_nxt  = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_SYNC;
          idle_nxt  = '0;
        end
        ST_SYNC: begin
          if (o_os_tick) begin
            idle_nxt = o_rx_sync ? idle_cnt + IDLE_W'(1) : '0;
            if (idle_nxt == IDLE_W'(IDLE_TARGET)) state_nxt = ST_RUN;
          end
        end
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  assign o_state    = state;
  assign o_core_rst = (state != ST_RUN);

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == PTR_W'(DEPTH));
  assign empty    = (count == '0);
  assign new_byte = i_core_ready && !ready_q && (state == ST_RUN);
  assign do_pop   = bus.i_rd && !empty && !bus.i_flush;
  assign do_push  = new_byte && !bus.i_flush && (!full || do_pop);
  assign drop     = new_byte && !bus.i_flush && full && !do_pop;

  // Previous core ready level for rising-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ready_q <= 1'b0;
    else       ready_q <= i_core_ready;
  end

  // FIFO pointers; flush drops everything including a same-cycle push
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.i_flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage; on push+pop at full the write lands in the slot being vacated
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_core_data;
  end

  // Sticky overrun; a new drop beats a same-cycle clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  overrun <= 1'b0;
    else if (drop)              overrun <= 1'b1;
    else if (bus.i_clr_overrun) overrun <= 1'b0;
  end

  assign bus.o_count   = count;
  assign bus.o_valid   = !empty;
  assign bus.o_data    = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign bus.o_overrun = overrun;

`ifdef UART_RX_CTRL_STATS_EN
  // Accepted-byte counter wraps; drop counter saturates
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_byte_count <= '0;
      o_drop_count <= '0;
    end else begin
      if (do_push) o_byte_count <= o_byte_count + 16'd1;
      if (drop && o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed, table-driven bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] divisor;
  logic        rx_pin;
  logic        rx_sync;
  logic        os_tick;
  logic        core_rst;
  logic [7:0]  core_data;
  logic        core_ready;
  logic [1:0]  state;
`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] byte_count;
  logic [7:0]  drop_count;
`endif

  uart_rx_ctrl_if #(.DATA(8), .DEPTH_LOG2(2)) bus ();

  uart_rx_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_divisor    (divisor),
    .i_rx_pin     (rx_pin),
    .o_rx_sync    (rx_sync),
    .o_os_tick    (os_tick),
    .o_core_rst   (core_rst),
    .i_core_data  (core_data),
    .i_core_ready (core_ready),
    .o_state      (state),
`ifdef UART_RX_CTRL_STATS_EN
    .o_byte_count (byte_count),
    .o_drop_count (drop_count),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       push;
    logic [7:0] d;
    logic       rd;
    logic       flush;
    logic       clr;
    logic [2:0] e_cnt;
    logic       e_val;
    logic [7:0] e_dat;
    logic       e_ov;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic p, input logic [7:0] d, input logic rd, input logic fl,
                              input logic clr, input logic [2:0] c, input logic v,
                              input logic [7:0] dat, input logic ov);
    vec_t r;
    r.push = p; r.d = d; r.rd = rd; r.flush = fl; r.clr = clr;
    r.e_cnt = c; r.e_val = v; r.e_dat = dat; r.e_ov = ov;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},    {30'd0, state}, 32'd0);
    chk({tag, "_rx_sync"},  {31'd0, rx_sync}, 32'd1);
    chk({tag, "_tick"},     {31'd0, os_tick}, 32'd0);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    chk({tag, "_count"},    {29'd0, bus.o_count}, 32'd0);
    chk({tag, "_valid"},    {31'd0, bus.o_valid}, 32'd0);
    chk({tag, "_data"},     {24'd0, bus.o_data}, 32'd0);
    chk({tag, "_overrun"},  {31'd0, bus.o_overrun}, 32'd0);
`ifdef UART_RX_CTRL_STATS_EN
    chk({tag, "_byte_cnt"}, {16'd0, byte_count}, 32'd0);
    chk({tag, "_drop_cnt"}, {24'd0, drop_count}, 32'd0);
`endif
  endtask

  // Enables from OFF and counts ticks seen in SYNC until RUN; optional one-cycle
  // low pulse timed so the synchronised line is low on tick number glitch_at.
  task automatic run_idle(input int glitch_at, output int n);
    n = 0;
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rx_pin = 1'b1;
      if (state == 2'd2) break;
      if (state == 2'd1 && os_tick) n++;
      if (glitch_at != 0 && n == glitch_at - 2) rx_pin = 1'b0;
    end
  endtask

  int n_ticks;

  initial begin
    // Table: starts in RUN with an empty FIFO and overrun clear
    vt.push_back(mk(1, 8'h55, 0, 0, 0, 3'd1, 1, 8'h55, 0));
    vt.push_back(mk(1, 8'hA3, 0, 0, 0, 3'd2, 1, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd1, 1, 8'hA3, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0));
    vt.push_back(mk(1, 8'h01, 0, 0, 0, 3'd1, 1, 8'h01, 0));
    vt.push_back(mk(1, 8'h02, 0, 0, 0, 3'd2, 1, 8'h01, 0));
    vt.push_back(mk(1, 8'h03, 0, 0, 0, 3'd3, 1, 8'h01, 0));
    vt.push_back(mk(1, 8'h04, 0, 0, 0, 3'd4, 1, 8'h01, 0));
    vt.push_back(mk(1, 8'h05, 0, 0, 0, 3'd4, 1, 8'h01, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 3'd4, 1, 8'h01, 0));
    vt.push_back(mk(1, 8'h06, 1, 0, 0, 3'd4, 1, 8'h02, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd3, 1, 8'h03, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd2, 1, 8'h04, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd1, 1, 8'h06, 0));
    vt.push_back(mk(1, 8'h10, 0, 0, 0, 3'd2, 1, 8'h06, 0));
    vt.push_back(mk(1, 8'h11, 0, 0, 0, 3'd3, 1, 8'h06, 0));
    vt.push_back(mk(1, 8'h12, 0, 0, 0, 3'd4, 1, 8'h06, 0));
    vt.push_back(mk(1, 8'h13, 0, 0, 0, 3'd4, 1, 8'h06, 1));
    vt.push_back(mk(1, 8'h77, 1, 1, 0, 3'd0, 0, 8'h00, 1));
    vt.push_back(mk(1, 8'h88, 0, 0, 1, 3'd1, 1, 8'h88, 0));
    vt.push_back(mk(1, 8'h99, 0, 0, 0, 3'd2, 1, 8'h88, 0));
    vt.push_back(mk(1, 8'hAA, 0, 0, 0, 3'd3, 1, 8'h88, 0));
    vt.push_back(mk(1, 8'hBB, 0, 0, 0, 3'd4, 1, 8'h88, 0));
    vt.push_back(mk(1, 8'hCC, 0, 0, 1, 3'd4, 1, 8'h88, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 3'd3, 1, 8'h99, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 3'd3, 1, 8'h99, 0));

    rst = 1'b1; en = 1'b0; divisor = 16'd3; rx_pin = 1'b1;
    core_data = 8'h00; core_ready = 1'b0;
    bus.i_rd = 1'b0; bus.i_flush = 1'b0; bus.i_clr_overrun = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Synchroniser latency: two edges from pin to o_rx_sync
    rx_pin = 1'b0;
    @(negedge clk);
    chk("sync_lat1", {31'd0, rx_sync}, 32'd1);
    @(negedge clk);
    chk("sync_lat2", {31'd0, rx_sync}, 32'd0);
    rx_pin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("sync_back", {31'd0, rx_sync}, 32'd1);

    // Tick every 4th cycle with divisor 3
    en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk($sformatf("tick_d3_%0d", k), {31'd0, os_tick}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("tick_off_%0d", k), {31'd0, os_tick}, 32'd0);
    end
    chk("state_off", {30'd0, state}, 32'd0);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("tick_reen_%0d", k), {31'd0, os_tick}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Divisor shrinks below the running count: tick fires on the next edge
    en = 1'b0;
    @(negedge clk);
    divisor = 16'd10;
    en = 1'b1;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    chk("tick_pre_shrink", {31'd0, os_tick}, 32'd0);
    divisor = 16'd3;
    @(negedge clk);
    chk("tick_shrink", {31'd0, os_tick}, 32'd1);

    // Idle gating with divisor 0 (tick every cycle)
    en = 1'b0;
    divisor = 16'd0;
    @(negedge clk);
    chk("off_before_idle", {30'd0, state}, 32'd0);
    run_idle(0, n_ticks);
    chk("idle_ticks", n_ticks, 32'd32);
    chk("idle_state_run", {30'd0, state}, 32'd2);
    chk("idle_core_rst", {31'd0, core_rst}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_state", {30'd0, state}, 32'd0);
    chk("en_off_core_rst", {31'd0, core_rst}, 32'd1);
    run_idle(20, n_ticks);
    chk("glitch_ticks", n_ticks, 32'd52);
    chk("glitch_state_run", {30'd0, state}, 32'd2);

    // FIFO table in RUN
    foreach (vt[i]) begin
      @(negedge clk);
      core_ready = vt[i].push;
      core_data = vt[i].d;
      bus.i_rd = vt[i].rd;
      bus.i_flush = vt[i].flush;
      bus.i_clr_overrun = vt[i].clr;
      @(negedge clk);
      core_ready = 1'b0;
      bus.i_rd = 1'b0;
      bus.i_flush = 1'b0;
      bus.i_clr_overrun = 1'b0;
      chk($sformatf("v%0d_count", i), {29'd0, bus.o_count}, {29'd0, vt[i].e_cnt});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.o_valid}, {31'd0, vt[i].e_val});
      chk($sformatf("v%0d_data", i), {24'd0, bus.o_data}, {24'd0, vt[i].e_dat});
      chk($sformatf("v%0d_overrun", i), {31'd0, bus.o_overrun}, {31'd0, vt[i].e_ov});
    end

    // Ready held high for several cycles: exactly one push
    @(negedge clk);
    core_ready = 1'b1;
    core_data = 8'hDD;
    for (int k = 0; k < 4; k++) @(negedge clk);
    core_ready = 1'b0;
    chk("level_count", {29'd0, bus.o_count}, 32'd4);
    chk("level_head", {24'd0, bus.o_data}, 32'h99);
    chk("level_overrun", {31'd0, bus.o_overrun}, 32'd0);

    // Drop on full sets overrun
    @(negedge clk);
    core_ready = 1'b1;
    core_data = 8'hEE;
    @(negedge clk);
    core_ready = 1'b0;
    chk("drop_count", {29'd0, bus.o_count}, 32'd4);
    chk("drop_overrun", {31'd0, bus.o_overrun}, 32'd1);
`ifdef UART_RX_CTRL_STATS_EN
    chk("stats_bytes", {16'd0, byte_count}, 32'd15);
    chk("stats_drops", {24'd0, drop_count}, 32'd4);
`endif

    // Disable: FIFO contents kept, no capture outside RUN
    en = 1'b0;
    @(negedge clk);
    chk("dis_state", {30'd0, state}, 32'd0);
    chk("dis_count", {29'd0, bus.o_count}, 32'd4);
    core_ready = 1'b1;
    core_data = 8'h11;
    @(negedge clk);
    core_ready = 1'b0;
    @(negedge clk);
    chk("dis_push_count", {29'd0, bus.o_count}, 32'd4);
    chk("dis_push_head", {24'd0, bus.o_data}, 32'h99);
`ifdef UART_RX_CTRL_STATS_EN
    chk("dis_stats_drops", {24'd0, drop_count}, 32'd4);
`endif

    // Asynchronous reset mid-RUN with a byte in flight
    run_idle(0, n_ticks);
    chk("rerun_state", {30'd0, state}, 32'd2);
    core_ready = 1'b1;
    core_data = 8'h5A;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    core_ready = 1'b0;
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
